mips_mc_controller: RTL

Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath mux selects and write enables, and generates the 3-bit ALU select for the existing ALU. It sits directly upstream of the ALU, and consumes the ALU zero flag for branch resolution.

---
 rtl/mips_pkg.sv | 53 +++++
 rtl/alu_decoder.sv | 36 +++
 rtl/mips_mc_controller.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the multicycle MIPS control path:
// opcodes, funct codes, ALU selects, ALU-op requests and FSM state encoding.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Request from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU-op request plus the R-type funct field onto the 3-bit
// ALU select; valid drops for funct codes the ALU does not implement.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] alu_op,
    output logic [2:0] alu_sel,
    output logic       valid
);

    // ALU select decode
    always_comb begin
        alu_sel = ALU_ADD;
        valid   = 1'b1;
        case (alu_op)
            ALUOP_ADD: alu_sel = ALU_ADD;
            ALUOP_SUB: alu_sel = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_sel = ALU_ADD;
                    FN_SUB:  alu_sel = ALU_SUB;
                    FN_AND:  alu_sel = ALU_AND;
                    FN_OR:   alu_sel = ALU_OR;
                    FN_SLT:  alu_sel = ALU_SLT;
                    default: begin
                        alu_sel = ALU_ADD;
                        valid   = 1'b0;
                    end
                endcase
            end
            default: alu_sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback and drives datapath selects, write enables and the ALU select.
module mips_mc_controller
    import mips_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int FN_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic [FN_W-1:0] funct,
    input  logic            zero,
    output logic [2:0]      alu_sel,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      pc_src,
    output logic            iord,
    output logic            ir_write,
    output logic            mem_write,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            pc_en,
    output logic            illegal,
    output logic [3:0]      state_dbg
);

    state_e     state_r;
    state_e     next_state_s;
    logic       bad_funct_r;
    logic [1:0] alu_op_s;
    logic       alu_use_s;
    logic [2:0] dec_sel_s;
    logic       dec_valid_s;
    logic       pc_write_s;
    logic       branch_s;

    alu_decoder u_alu_decoder (
        .funct   (funct),
        .alu_op  (alu_op_s),
        .alu_sel (dec_sel_s),
        .valid   (dec_valid_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Remembers an unsupported funct from EXECUTE so ALUWB skips its write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bad_funct_r <= 1'b0;
        end else if (state_r == S_EXECUTE) begin
            bad_funct_r <= ~dec_valid_s;
        end else if (state_r == S_FETCH) begin
            bad_funct_r <= 1'b0;
        end else begin
            bad_funct_r <= bad_funct_r;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH: next_state_s = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_RTYPE:     next_state_s = S_EXECUTE;
                    OP_BEQ:       next_state_s = S_BRANCH;
                    OP_ADDI:      next_state_s = S_ADDIEX;
                    OP_J:         next_state_s = S_JUMP;
                    default:      next_state_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    next_state_s = S_MEMRD;
                end else if (op == OP_SW) begin
                    next_state_s = S_MEMWR;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_MEMRD:   next_state_s = S_MEMWB;
            S_MEMWB:   next_state_s = S_FETCH;
            S_MEMWR:   next_state_s = S_FETCH;
            S_EXECUTE: next_state_s = S_ALUWB;
            S_ALUWB:   next_state_s = S_FETCH;
            S_BRANCH:  next_state_s = S_FETCH;
            S_ADDIEX:  next_state_s = S_ADDIWB;
            S_ADDIWB:  next_state_s = S_FETCH;
            S_JUMP:    next_state_s = S_FETCH;
            default:   next_state_s = S_FETCH;
        endcase
    end

    // ALU-op request; kept apart from the output decode to avoid a comb loop through the decoder
    always_comb begin
        alu_op_s  = ALUOP_ADD;
        alu_use_s = 1'b0;
        if (!rst_n) begin
            alu_use_s = 1'b1;
        end else begin
            case (state_r)
                S_FETCH, S_DECODE, S_MEMADR, S_ADDIEX: alu_use_s = 1'b1;
                S_EXECUTE: begin
                    alu_op_s  = ALUOP_FUNCT;
                    alu_use_s = 1'b1;
                end
                S_BRANCH: begin
                    alu_op_s  = ALUOP_SUB;
                    alu_use_s = 1'b1;
                end
                default: alu_use_s = 1'b0;
            endcase
        end
    end

    // Moore output decode; reset holds FETCH selects with every enable off
    always_comb begin
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_write_s = 1'b0;
        branch_s   = 1'b0;
        illegal    = 1'b0;
        if (!rst_n) begin
            alu_src_b = 2'b01;
        end else begin
            case (state_r)
                S_FETCH: begin
                    alu_src_b  = 2'b01;
                    ir_write   = 1'b1;
                    pc_write_s = 1'b1;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    illegal   = ~op_supported(op);
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: iord = 1'b1;
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    illegal   = ~dec_valid_s;
                end
                S_ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = ~bad_funct_r;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    pc_src    = 2'b01;
                    branch_s  = 1'b1;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDIWB: reg_write = 1'b1;
                S_JUMP: begin
                    pc_src     = 2'b10;
                    pc_write_s = 1'b1;
                end
                default: alu_src_b = 2'b00;
            endcase
        end
    end

    assign alu_sel   = alu_use_s ? dec_sel_s : ALU_AND;
    assign pc_en     = pc_write_s | (branch_s & zero);
    assign state_dbg = state_r;

endmodule
